note_hit_scorer: RTL and testbench

- Receives per-note hit flags and note-finished flags from the lane droppers, once per frame.
- Detects the frame in which each note is hit or missed.
- Maintains total score, current combo, max combo, hit/miss counts and a final grade.
- Sits between the dropper array and the HUD/text renderer, and owns the start/play/result game flow.

---
 rtl/note_hit_scorer_if.sv | 28 ++
 rtl/note_hit_scorer.sv | 184 ++++++++++++++++++
 tb/tb_note_hit_scorer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/note_hit_scorer_if.sv
// Bundle between the dropper array/keyboard and the scorer, plus the HUD-facing results.
interface note_hit_scorer_if #(
    parameter int NUM_NOTES = 24
);
    logic [7:0]           keycode;
    logic [NUM_NOTES-1:0] score_in;
    logic [NUM_NOTES-1:0] done_in;
    logic [15:0]          total_score;
    logic [7:0]           combo;
    logic [7:0]           max_combo;
    logic [7:0]           hit_count;
    logic [7:0]           miss_count;
    logic                 hit_flash;
    logic                 result_valid;
    logic [1:0]           grade;

    modport master (
        output keycode, score_in, done_in,
        input  total_score, combo, max_combo, hit_count, miss_count,
        input  hit_flash, result_valid, grade
    );

    modport slave (
        input  keycode, score_in, done_in,
        output total_score, combo, max_combo, hit_count, miss_count,
        output hit_flash, result_valid, grade
    );
endinterface

// File: rtl/note_hit_scorer.sv
// Per-frame hit/miss edge scoring with combo multiplier and Idle/Play/Result game flow.
module note_hit_scorer #(
    parameter int NUM_NOTES  = 24,
    parameter int HIT_POINTS = 10,
    parameter int MULT_SHIFT = 3,
    parameter int MULT_MAX   = 4
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    note_hit_scorer_if.slave     bus
);
    localparam int CW = $clog2(NUM_NOTES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t               state_q;
    logic [NUM_NOTES-1:0] prev_score_q;
    logic [NUM_NOTES-1:0] prev_done_q;
    logic [15:0]          total_q;
    logic [7:0]           combo_q;
    logic [7:0]           max_combo_q;
    logic [7:0]           hit_cnt_q;
    logic [7:0]           miss_cnt_q;
    logic                 hit_flash_q;
    logic                 result_valid_q;
    logic [1:0]           grade_q;

    logic [NUM_NOTES-1:0] hit_vec_s;
    logic [NUM_NOTES-1:0] miss_vec_s;
    logic [CW-1:0]        nh_s;
    logic [CW-1:0]        nm_s;
    logic [7:0]           step_s;
    logic [2:0]           mult_s;
    logic [9:0]           pts_s;
    logic [16:0]          score_sum_s;
    logic [8:0]           hit_sum_s;
    logic [8:0]           miss_sum_s;
    logic [8:0]           combo_sum_s;
    logic [15:0]          total_d;
    logic [7:0]           hit_cnt_d;
    logic [7:0]           miss_cnt_d;
    logic [7:0]           combo_d;
    logic [7:0]           max_combo_d;
    logic [1:0]           grade_d;
    logic [10:0]          hits_ext_s;

    function automatic logic [CW-1:0] popcount(input logic [NUM_NOTES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // A note that finishes in the same frame it is hit counts only as a hit.
    assign hit_vec_s   = bus.score_in & ~prev_score_q;
    assign miss_vec_s  = bus.done_in & ~prev_done_q & ~bus.score_in;
    assign nh_s        = popcount(hit_vec_s);
    assign nm_s        = popcount(miss_vec_s);
    assign step_s      = combo_q >> MULT_SHIFT;
    assign pts_s       = 10'(nh_s) * 10'(HIT_POINTS) * 10'(mult_s);
    assign score_sum_s = {1'b0, total_q} + {7'd0, pts_s};
    assign hit_sum_s   = {1'b0, hit_cnt_q} + 9'(nh_s);
    assign miss_sum_s  = {1'b0, miss_cnt_q} + 9'(nm_s);
    assign combo_sum_s = {1'b0, combo_q} + 9'(nh_s);
    assign total_d     = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
    assign hit_cnt_d   = hit_sum_s[8] ? 8'hFF : hit_sum_s[7:0];
    assign miss_cnt_d  = miss_sum_s[8] ? 8'hFF : miss_sum_s[7:0];
    assign hits_ext_s  = {3'b000, hit_cnt_d};

    // Multiplier from the pre-update combo, clamped at the ceiling.
    always_comb begin
        mult_s = 3'd1;
        if (step_s >= 8'(MULT_MAX - 1)) begin
            mult_s = 3'(MULT_MAX);
        end else begin
            mult_s = 3'(step_s + 8'd1);
        end
    end

    // Next combo/max combo; any miss this frame breaks the chain.
    always_comb begin
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        if (nm_s != '0) begin
            combo_d = 8'd0;
        end else if (combo_sum_s[8]) begin
            combo_d = 8'hFF;
        end else begin
            combo_d = combo_sum_s[7:0];
        end
        if (combo_d > max_combo_q) begin
            max_combo_d = combo_d;
        end else begin
            max_combo_d = max_combo_q;
        end
    end

    // Grade thresholds on the hit count as it stands after the final frame.
    always_comb begin
        grade_d = 2'd0;
        if ((hits_ext_s << 2) >= 11'(NUM_NOTES * 3)) begin
            grade_d = 2'd3;
        end else if ((hits_ext_s << 1) >= 11'(NUM_NOTES)) begin
            grade_d = 2'd2;
        end else if ((hits_ext_s << 2) >= 11'(NUM_NOTES)) begin
            grade_d = 2'd1;
        end else begin
            grade_d = 2'd0;
        end
    end

    // Game-flow FSM and all registered outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            prev_score_q   <= '0;
            prev_done_q    <= '0;
            total_q        <= 16'd0;
            combo_q        <= 8'd0;
            max_combo_q    <= 8'd0;
            hit_cnt_q      <= 8'd0;
            miss_cnt_q     <= 8'd0;
            hit_flash_q    <= 1'b0;
            result_valid_q <= 1'b0;
            grade_q        <= 2'd0;
        end else begin
            // Edge history tracks in every state so a restart sees no stale edges.
            prev_score_q <= bus.score_in;
            prev_done_q  <= bus.done_in;
            hit_flash_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.keycode == 8'h2C) begin
                        state_q     <= S_PLAY;
                        total_q     <= 16'd0;
                        combo_q     <= 8'd0;
                        max_combo_q <= 8'd0;
                        hit_cnt_q   <= 8'd0;
                        miss_cnt_q  <= 8'd0;
                        grade_q     <= 2'd0;
                    end
                end
                S_PLAY: begin
                    total_q     <= total_d;
                    combo_q     <= combo_d;
                    max_combo_q <= max_combo_d;
                    hit_cnt_q   <= hit_cnt_d;
                    miss_cnt_q  <= miss_cnt_d;
                    hit_flash_q <= (nh_s != '0);
                    if (&bus.done_in) begin
                        state_q        <= S_RESULT;
                        result_valid_q <= 1'b1;
                        grade_q        <= grade_d;
                    end
                end
                S_RESULT: begin
                    if (bus.keycode == 8'h01) begin
                        state_q        <= S_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.total_score  = total_q;
    assign bus.combo        = combo_q;
    assign bus.max_combo    = max_combo_q;
    assign bus.hit_count    = hit_cnt_q;
    assign bus.miss_count   = miss_cnt_q;
    assign bus.hit_flash    = hit_flash_q;
    assign bus.result_valid = result_valid_q;
    assign bus.grade        = grade_q;
endmodule

// File: tb/tb_note_hit_scorer.sv
// Table-driven and sequence checks of note_hit_scorer through a scoreboard queue.
module tb_note_hit_scorer;
    localparam int N = 24;
    localparam logic [N-1:0] ALL = {N{1'b1}};

    typedef struct packed {
        logic [15:0] total;
        logic [7:0]  combo;
        logic [7:0]  maxc;
        logic [7:0]  hits;
        logic [7:0]  misses;
        logic        flash;
        logic        rv;
        logic [1:0]  grade;
    } exp_t;

    typedef struct packed {
        logic         rst;
        logic [7:0]   kc;
        logic [N-1:0] sc;
        logic [N-1:0] dn;
        exp_t         e;
    } vec_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    exp_t q[$];
    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;

    note_hit_scorer_if #(.NUM_NOTES(N)) bus ();

    note_hit_scorer #(.NUM_NOTES(N)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic exp_t mk(int t, int c, int m, int h, int mi, int f, int rv, int g);
        exp_t e;
        e.total  = 16'(t);
        e.combo  = 8'(c);
        e.maxc   = 8'(m);
        e.hits   = 8'(h);
        e.misses = 8'(mi);
        e.flash  = 1'(f);
        e.rv     = 1'(rv);
        e.grade  = 2'(g);
        return e;
    endfunction

    function automatic vec_t v(logic rst, logic [7:0] kc, logic [N-1:0] sc, logic [N-1:0] dn, exp_t e);
        vec_t r;
        r.rst = rst;
        r.kc  = kc;
        r.sc  = sc;
        r.dn  = dn;
        r.e   = e;
        return r;
    endfunction

    function automatic logic [N-1:0] mask(int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[N-1:0];
    endfunction

    task automatic step(input string name, input logic rst, input logic [7:0] kc,
                        input logic [N-1:0] sc, input logic [N-1:0] dn, input exp_t e);
        exp_t got;
        exp_t want;
        @(negedge frame_clk);
        Reset        = rst;
        bus.keycode  = kc;
        bus.score_in = sc;
        bus.done_in  = dn;
        q.push_back(e);
        @(posedge frame_clk);
        #1;
        got = {bus.total_score, bus.combo, bus.max_combo, bus.hit_count,
               bus.miss_count, bus.hit_flash, bus.result_valid, bus.grade};
        want = q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got score=%0d combo=%0d max=%0d hits=%0d misses=%0d flash=%b rv=%b grade=%0d; expected score=%0d combo=%0d max=%0d hits=%0d misses=%0d flash=%b rv=%b grade=%0d",
                     name, got.total, got.combo, got.maxc, got.hits, got.misses, got.flash, got.rv, got.grade,
                     want.total, want.combo, want.maxc, want.hits, want.misses, want.flash, want.rv, want.grade);
        end
    endtask

    task automatic grade_game(input int n, input int g);
        int c;
        c = (n == N) ? n : 0;
        step($sformatf("g%0d_start", n), 1'b0, 8'h2C, '0, '0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step($sformatf("g%0d_hits", n), 1'b0, 8'h00, mask(n), '0, mk(10 * n, n, n, n, 0, (n > 0) ? 1 : 0, 0, 0));
        step($sformatf("g%0d_result", n), 1'b0, 8'h00, mask(n), ALL, mk(10 * n, c, n, n, N - n, 0, 1, g));
        step($sformatf("g%0d_exit", n), 1'b0, 8'h01, '0, '0, mk(10 * n, c, n, n, N - n, 0, 0, g));
    endtask

    initial begin
        int m_total, m_combo, m_max, m_hit, mult;
        bus.keycode  = 8'h00;
        bus.score_in = '0;
        bus.done_in  = '0;

        tv.push_back(v(1'b1, 8'h00, '0, '0, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        tv.push_back(v(1'b0, 8'h2C, '0, '0, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        for (int k = 1; k <= 8; k++) begin
            tv.push_back(v(1'b0, 8'h00, mask(k), '0, mk(10 * k, k, k, k, 0, 1, 0, 0)));
        end
        tv.push_back(v(1'b0, 8'h00, 24'h0001FF, 24'h000000, mk(100, 9, 9, 9, 0, 1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h0001FF, 24'h000000, mk(100, 9, 9, 9, 0, 0, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h0001FF, 24'h000200, mk(100, 0, 9, 9, 1, 0, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h000DFF, 24'h001200, mk(120, 0, 9, 11, 2, 1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h002DFF, 24'h003200, mk(130, 1, 9, 12, 2, 1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h0FEDFF, 24'hF03200, mk(190, 0, 9, 18, 6, 1, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h0FEDFF, ALL, mk(190, 0, 9, 18, 6, 0, 1, 3)));
        tv.push_back(v(1'b0, 8'h00, 24'h000000, ALL, mk(190, 0, 9, 18, 6, 0, 1, 3)));
        tv.push_back(v(1'b0, 8'h00, ALL, ALL, mk(190, 0, 9, 18, 6, 0, 1, 3)));
        tv.push_back(v(1'b0, 8'h01, ALL, ALL, mk(190, 0, 9, 18, 6, 0, 0, 3)));
        tv.push_back(v(1'b0, 8'h00, 24'h000000, 24'h000000, mk(190, 0, 9, 18, 6, 0, 0, 3)));
        tv.push_back(v(1'b0, 8'h00, 24'h000001, 24'h000000, mk(190, 0, 9, 18, 6, 0, 0, 3)));
        tv.push_back(v(1'b0, 8'h2C, 24'h000001, 24'h000000, mk(0, 0, 0, 0, 0, 0, 0, 0)));
        tv.push_back(v(1'b0, 8'h00, 24'h000001, 24'h000000, mk(0, 0, 0, 0, 0, 0, 0, 0)));

        foreach (tv[i]) begin
            step($sformatf("vec%0d", i), tv[i].rst, tv[i].kc, tv[i].sc, tv[i].dn, tv[i].e);
        end

        // Reset mid-Play, then restart with levels already high.
        step("mid_hits", 1'b0, 8'h00, 24'h00003F, '0, mk(50, 5, 5, 5, 0, 1, 0, 0));
        step("mid_reset", 1'b1, 8'h00, 24'h00003F, '0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step("idle_edge", 1'b0, 8'h00, 24'h00007F, '0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step("restart", 1'b0, 8'h2C, 24'h00007F, '0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step("stale_lvl", 1'b0, 8'h00, 24'h00007F, '0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        step("fresh_hit", 1'b0, 8'h00, 24'h0000FF, '0, mk(10, 1, 1, 1, 0, 1, 0, 0));
        step("end_miss", 1'b0, 8'h00, 24'h0000FF, ALL, mk(10, 0, 1, 1, 16, 0, 1, 0));
        step("to_idle", 1'b0, 8'h01, '0, '0, mk(10, 0, 1, 1, 16, 0, 0, 0));

        // Grade thresholds around each boundary.
        grade_game(24, 3);
        grade_game(18, 3);
        grade_game(17, 2);
        grade_game(12, 2);
        grade_game(11, 1);
        grade_game(6, 1);
        grade_game(5, 0);

        // Long toggle run: multiplier ceiling and all saturations.
        step("sat_start", 1'b0, 8'h2C, '0, '0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        m_total = 0; m_combo = 0; m_max = 0; m_hit = 0;
        for (int k = 0; k < 1700; k++) begin
            mult = 1 + (m_combo >> 3);
            if (mult > 4) mult = 4;
            m_total = m_total + 10 * mult;
            if (m_total > 65535) m_total = 65535;
            if (m_hit < 255) m_hit++;
            if (m_combo < 255) m_combo++;
            if (m_combo > m_max) m_max = m_combo;
            step($sformatf("sat_rise%0d", k), 1'b0, 8'h00, 24'h000001, '0,
                 mk(m_total, m_combo, m_max, m_hit, 0, 1, 0, 0));
            step($sformatf("sat_fall%0d", k), 1'b0, 8'h00, 24'h000000, '0,
                 mk(m_total, m_combo, m_max, m_hit, 0, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
